divide: RTL and testbench

DIVIDE -- requirements
Module: divide

---
 rtl/divide_pkg.sv | 25 ++
 rtl/div_step.sv | 30 +++
 rtl/divide.sv | 130 +++++++++++++
 tb/tb_divide.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divide_pkg.sv
// Shared constants and types for the radix-16 restoring divider.
// WIDTH default, bits retired per cycle, iteration count and FSM states.
package divide_pkg;

    localparam int WIDTH_DEF      = 32;
    localparam int BITS_PER_CYCLE = 4;
    localparam int ITERATIONS     = WIDTH_DEF / BITS_PER_CYCLE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of BUSY cycles needed for an arbitrary operand width
    function automatic int iter_count(input int w);
        return w / BITS_PER_CYCLE;
    endfunction

    // Counter width that stays legal even for a single iteration
    function automatic int cnt_width(input int w);
        return (iter_count(w) > 1) ? $clog2(iter_count(w)) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit,
// compare against the divisor, subtract when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] shifted_w;
    logic [WIDTH+1:0] div_ext_w;
    logic             ge_w;

    // Shift/compare/conditional-subtract, one quotient bit out
    always_comb begin
        shifted_w = {rem_i, bit_i};
        div_ext_w = {2'b00, div_i};
        ge_w      = (shifted_w >= div_ext_w);
        q_o       = ge_w;
        if (ge_w) begin
            rem_o = (WIDTH+1)'(shifted_w - div_ext_w);
        end else begin
            rem_o = shifted_w[WIDTH:0];
        end
    end

endmodule

// File: rtl/divide.sv
// Unsigned sequential divider, 4 quotient bits per BUSY cycle.
// Divide-by-zero returns all-ones quotient and the dividend as remainder.
module divide
    import divide_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] R,
    output logic             ok,
    output logic             err
);

    localparam int BPC  = BITS_PER_CYCLE;
    localparam int ITER = iter_count(WIDTH);
    localparam int CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] r_q;
    logic             ok_q;
    logic             err_q;

    logic [BPC:0][WIDTH:0] rem_c;
    logic [BPC-1:0]        qbits_w;
    logic [WIDTH:0]        rem_d;
    logic [WIDTH-1:0]      quo_d;
    logic [WIDTH-1:0]      a_d;

    assign rem_c[0] = rem_q;

    // Four cascaded radix-2 steps, dividend MSB first
    for (genvar k = 0; k < BPC; k++) begin : g_step
        div_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .rem_i (rem_c[k]),
            .bit_i (a_q[WIDTH-1-k]),
            .div_i (b_q),
            .rem_o (rem_c[k+1]),
            .q_o   (qbits_w[BPC-1-k])
        );
    end

    // Next accumulator, quotient and dividend after one BUSY cycle
    always_comb begin
        rem_d = rem_c[BPC];
        quo_d = (quo_q << BPC) | WIDTH'(qbits_w);
        a_d   = a_q << BPC;
    end

    // Control FSM with operand, accumulator and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
            r_q     <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        rem_q <= '0;
                        quo_q <= '0;
                        cnt_q <= '0;
                        ok_q  <= 1'b0;
                        err_q <= 1'b0;
                        if (B == '0) begin
                            d_q     <= '1;
                            r_q     <= A;
                            ok_q    <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    a_q   <= a_d;
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        d_q     <= quo_d;
                        r_q     <= rem_d[WIDTH-1:0];
                        ok_q    <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        ok_q    <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign D   = d_q;
    assign R   = r_q;
    assign ok  = ok_q;
    assign err = err_q;

endmodule

// File: tb/tb_divide.sv
// Self-checking bench for the divide unit.
// Expected results are queued at issue time and compared on ok.
module tb_divide;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] D;
    logic [31:0] R;
    logic        ok;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d;
        logic [31:0] r;
        logic        e;
    } exp_t;

    exp_t sb[$];

    divide #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .D     (D),
        .R     (R),
        .ok    (ok),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
        exp_t x;
        if (b == 32'd0) begin
            x.d = 32'hFFFF_FFFF;
            x.r = a;
            x.e = 1'b1;
        end else begin
            x.d = a / b;
            x.r = a % b;
            x.e = 1'b0;
        end
        sb.push_back(x);
    endtask

    // Drive a request from IDLE; returns just after the accepting edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        push_exp(a, b);
        @(posedge clk);
        #1;
    endtask

    // Count edges until ok rises, bounded
    task automatic await_ok(output int lat, output bit to);
        lat = 0;
        while (ok !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        to = (ok !== 1'b1);
    endtask

    task automatic release_start;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int   lat;
        bit   to;
        exp_t x;
        bit   stable;
        reset = 1'b1;
        start = 1'b1;
        A = 32'd1023;
        B = 32'd50;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({D, R, ok, err} !== 66'd0) begin
            failures++;
            $display("FAIL reset_state: D=%h R=%h ok=%b err=%b want all 0",
                     D, R, ok, err);
        end
        push_exp(32'd1023, 32'd50);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        await_ok(lat, to);
        checks++;
        if (to || lat != 8) begin
            failures++;
            $display("FAIL reset_start_latency: lat=%0d to=%0b want 8",
                     lat, to);
        end
        x = sb.pop_front();
        checks++;
        if (D !== 32'd20 || R !== 32'd23 || err !== 1'b0 ||
            D !== x.d || R !== x.r) begin
            failures++;
            $display("FAIL basic_1023_50: D=%0d R=%0d err=%b want 20 23 0",
                     D, R, err);
        end
        stable = 1'b1;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (D !== 32'd20 || R !== 32'd23 || ok !== 1'b1 || err !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL hold_start: D=%0d R=%0d ok=%b want 20 23 1 stable",
                     D, R, ok);
        end
        release_start();
        checks++;
        if (ok !== 1'b0 || D !== 32'd20 || R !== 32'd23) begin
            failures++;
            $display("FAIL drop_start: ok=%b D=%0d R=%0d want 0 20 23",
                     ok, D, R);
        end
    endtask

    task automatic test_div_zero;
        int   lat;
        bit   to;
        exp_t x;
        issue(32'd7, 32'd0);
        await_ok(lat, to);
        x = sb.pop_front();
        checks++;
        if (to || lat != 0) begin
            failures++;
            $display("FAIL divzero_latency: lat=%0d to=%0b want 0", lat, to);
        end
        checks++;
        if (D !== x.d || R !== x.r || err !== 1'b1 || ok !== 1'b1) begin
            failures++;
            $display("FAIL divzero: D=%h R=%h err=%b want %h %h 1",
                     D, R, err, x.d, x.r);
        end
        release_start();
        checks++;
        if (ok !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL divzero_clear: ok=%b err=%b want 0 0", ok, err);
        end
    endtask

    task automatic test_boundaries;
        logic [31:0] ta[6];
        logic [31:0] tb[6];
        int          lat;
        bit          to;
        exp_t        x;
        ta = '{32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
               32'd0, 32'd5};
        tb = '{32'd13, 32'd1, 32'hFFFF_FFFF, 32'h8000_0001,
               32'd5, 32'd5};
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i]);
            await_ok(lat, to);
            x = sb.pop_front();
            checks++;
            if (to || lat != 8 || D !== x.d || R !== x.r || err !== x.e) begin
                failures++;
                $display("FAIL boundary_%0d: A=%h B=%h D=%h R=%h err=%b lat=%0d want %h %h %b 8",
                         i, ta[i], tb[i], D, R, err, lat, x.d, x.r, x.e);
            end
            release_start();
        end
    endtask

    task automatic test_abort;
        int   lat;
        bit   to;
        exp_t x;
        issue(32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (D !== 32'd0 || R !== 32'd0 || ok !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset: D=%h R=%h ok=%b err=%b want 0 0 0 0",
                     D, R, ok, err);
        end
        x = sb.pop_front();
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        issue(32'd100, 32'd7);
        await_ok(lat, to);
        x = sb.pop_front();
        checks++;
        if (to || D !== 32'd14 || R !== 32'd2 || D !== x.d || R !== x.r) begin
            failures++;
            $display("FAIL after_abort: D=%0d R=%0d to=%0b want 14 2",
                     D, R, to);
        end
    endtask

    task automatic test_handshake;
        int   lat;
        bit   to;
        exp_t x;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ok !== 1'b0 || D !== 32'd14 || R !== 32'd2) begin
            failures++;
            $display("FAIL handshake_hold: ok=%b D=%0d R=%0d want 0 14 2",
                     ok, D, R);
        end
        issue(32'd1000, 32'd3);
        @(negedge clk);
        A = 32'hDEAD_BEEF;
        B = 32'd0;
        start = 1'b0;
        @(negedge clk);
        A = 32'd5;
        B = 32'd1;
        start = 1'b1;
        await_ok(lat, to);
        x = sb.pop_front();
        checks++;
        if (to || D !== 32'd333 || R !== 32'd1 || err !== 1'b0 ||
            D !== x.d || R !== x.r) begin
            failures++;
            $display("FAIL handshake_1000_3: D=%0d R=%0d err=%b to=%0b want 333 1 0",
                     D, R, err, to);
        end
        release_start();
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        bit          to;
        exp_t        x;
        logic [63:0] recon;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 4)
                1: b = 32'($urandom_range(1, 255));
                2: b = b | 32'h8000_0000;
                3: a = b >> $urandom_range(0, 8);
                default: ;
            endcase
            if (b == 32'd0) b = 32'd1;
            issue(a, b);
            await_ok(lat, to);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL random_queue: empty want 1 entry");
            end else begin
                x = sb.pop_front();
                recon = 64'(D) * 64'(b) + 64'(R);
                checks++;
                if (to || lat != 8 || D !== x.d || R !== x.r || err !== 1'b0 ||
                    recon !== 64'(a) || !(R < b)) begin
                    failures++;
                    $display("FAIL random_%0d: A=%h B=%h D=%h R=%h lat=%0d want %h %h",
                             i, a, b, D, R, lat, x.d, x.r);
                end
            end
            release_start();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        test_reset();
        test_div_zero();
        test_boundaries();
        test_abort();
        test_handshake();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
